// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers: ID/EXE control bit map,
// architectural widths and default bundle sizes.
package pipe_pkg;
    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    // ID/EXE control bundle bit positions
    localparam int WREG     = 0;
    localparam int M2REG    = 1;
    localparam int WMEM     = 2;
    localparam int JAL      = 3;
    localparam int ALUIMM   = 4;
    localparam int SHIFT    = 5;
    localparam int ALUC_LSB = 6;
    localparam int ALUC_W   = 4;
    localparam int RN_LSB   = ALUC_LSB + ALUC_W;
    localparam int RN_W     = REG_ADDR_W;
    localparam int IDEXE_CTRL_BITS = RN_LSB + RN_W;

    localparam int CTRL_W_DEF = 16;
    localparam int DATA_W_DEF = 4 * WORD_W;
    localparam int CNT_W_DEF  = 16;

    typedef struct packed {
        logic [CTRL_W_DEF-IDEXE_CTRL_BITS-1:0] rsvd;
        logic [RN_W-1:0]   rn;
        logic [ALUC_W-1:0] aluc;
        logic              shift;
        logic              aluimm;
        logic              jal;
        logic              wmem;
        logic              m2reg;
        logic              wreg;
    } idexe_ctrl_t;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] imm;
        logic [WORD_W-1:0] pc4;
    } idexe_data_t;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready bundle of one pipeline register stage.
// slave = the stage itself, master = the surrounding pipeline.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_skid_slot.sv
// Single-entry holding register (valid + ctrl + data). Control is zeroed whenever
// the slot empties so a bubble can never carry live write enables.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ld,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    // load wins over clear: a pop with a same-cycle refill keeps the slot full
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (ld) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, flush and a saturating bubble counter.
// Define PIPE_SKID_EN to add a 1-entry skid slot and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             stall,
    pipe_stage_reg_if.slave  bus,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic              live, pop, acc, in_ready;
    logic              main_valid, main_ld, main_clr, nxt_valid;
    logic [CTRL_W-1:0] main_ctrl, main_d_ctrl;
    logic [DATA_W-1:0] main_data, main_d_data;

    // flush dominates stall, both freeze the handshake
    assign live = !stall && !flush;
    assign pop  = live && main_valid && bus.out_ready;

`ifdef PIPE_SKID_EN
    logic              skid_valid, skid_ld, skid_clr;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // ready depends only on state and the hazard inputs, never on out_ready
    assign in_ready    = resetn && live && !skid_valid;
    assign acc         = bus.in_valid && in_ready;
    assign main_ld     = (pop && skid_valid) || (acc && (!main_valid || pop));
    assign main_d_ctrl = skid_valid ? skid_ctrl : bus.in_ctrl;
    assign main_d_data = skid_valid ? skid_data : bus.in_data;
    assign skid_ld     = acc && main_valid && !pop;
    assign skid_clr    = flush || (pop && skid_valid);
    assign occ         = {1'b0, main_valid} + {1'b0, skid_valid};

    pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clock  (clock),
        .resetn (resetn),
        .ld     (skid_ld),
        .clr    (skid_clr),
        .d_ctrl (bus.in_ctrl),
        .d_data (bus.in_data),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data)
    );
`else
    assign in_ready    = resetn && live && (!main_valid || bus.out_ready);
    assign acc         = bus.in_valid && in_ready;
    assign main_ld     = acc;
    assign main_d_ctrl = bus.in_ctrl;
    assign main_d_data = bus.in_data;
    assign occ         = {1'b0, main_valid};
`endif

    assign main_clr  = flush || pop;
    assign nxt_valid = main_ld || (main_valid && !main_clr);

    pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clock  (clock),
        .resetn (resetn),
        .ld     (main_ld),
        .clr    (main_clr),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .valid  (main_valid),
        .ctrl   (main_ctrl),
        .data   (main_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            bubble_cnt <= '0;
        else if (!nxt_valid && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.out_data  = main_data;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised self-checking bench for pipe_stage_reg against a queue-based model.
module tb_pipe_stage_reg;
    localparam int CW = 16;
    localparam int DW = 128;
    localparam int NW = 16;
    localparam int SW = 4;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0;
    logic stall = 1'b0;
    logic [1:0]    occ, occ_s;
    logic [NW-1:0] bcnt;
    logic [SW-1:0] bcnt_s;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus_s ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clock(clock), .resetn(resetn), .flush(flush), .stall(stall),
        .bus(bus), .occ(occ), .bubble_cnt(bcnt));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(SW)) dut_s (
        .clock(clock), .resetn(resetn), .flush(1'b0), .stall(1'b0),
        .bus(bus_s), .occ(occ_s), .bubble_cnt(bcnt_s));

    always #5 clock = ~clock;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   m_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic exp_ready();
        if (!resetn || stall || flush) return 1'b0;
        return (mq.size() < CAP) || (CAP == 1 && bus.out_ready);
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.c = 16'($urandom);
        e.d = {$urandom, $urandom, $urandom, $urandom};
        return e;
    endfunction

    task automatic drive(input logic v, input ent_t e);
        bus.in_valid = v;
        bus.in_ctrl  = e.c;
        bus.in_data  = e.d;
    endtask

    // advance model using the inputs currently applied, then cross one edge
    task automatic tick();
        logic rdy;
        ent_t e;
        rdy = exp_ready();
        if (resetn) begin
            if (flush) mq.delete();
            else if (!stall) begin
                if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
                if (bus.in_valid && rdy) begin
                    e.c = bus.in_ctrl;
                    e.d = bus.in_data;
                    mq.push_back(e);
                end
            end
            if (mq.size() == 0 && m_cnt < (1 << NW) - 1) m_cnt++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        resetn = 1'b0;
        mq.delete();
        m_cnt = 0;
    endtask

    task automatic test_reset();
        ent_t e;
        e = rnd_ent();
        drive(1'b0, e);
        bus.out_ready = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        drive(1'b1, e);
        tick();
        drive(1'b0, e);
        tick();
        model_reset();
        drive(1'b1, rnd_ent());
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", bus.out_valid); end
        checks++; if (bus.out_ctrl !== '0) begin errors++; $display("FAIL rst_ctrl got %0h exp 0", bus.out_ctrl); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL rst_data got %0h exp 0", bus.out_data); end
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occ); end
        checks++; if (bcnt !== '0) begin errors++; $display("FAIL rst_bcnt got %0d exp 0", bcnt); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0h exp 0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid got %0h exp 0", bus.out_valid); end
        resetn = 1'b1;
        e.c = 16'h00A5;
        e.d = 128'h1234;
        drive(1'b1, e);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %0h exp 1", bus.in_ready); end
        tick();
        drive(1'b0, e);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rel_valid got %0h exp 1", bus.out_valid); end
        checks++; if (bus.out_ctrl !== 16'h00A5) begin errors++; $display("FAIL rel_ctrl got %0h exp a5", bus.out_ctrl); end
        checks++; if (bus.out_data !== 128'h1234) begin errors++; $display("FAIL rel_data got %0h exp 1234", bus.out_data); end
        checks++; if (bcnt !== '0) begin errors++; $display("FAIL rel_bcnt got %0d exp 0", bcnt); end
    endtask

    task automatic test_stream();
        ent_t sent[10];
        int bc0;
        bc0 = m_cnt;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sent[i] = rnd_ent();
            drive(1'b1, sent[i]);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %0h exp 1", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0h exp 1", i, bus.out_valid); end
            checks++; if (bus.out_ctrl !== sent[i].c) begin errors++; $display("FAIL stream_ctrl[%0d] got %0h exp %0h", i, bus.out_ctrl, sent[i].c); end
            checks++; if (bus.out_data !== sent[i].d) begin errors++; $display("FAIL stream_data[%0d] got %0h exp %0h", i, bus.out_data, sent[i].d); end
        end
        drive(1'b0, sent[0]);
        checks++; if (bcnt !== NW'(bc0)) begin errors++; $display("FAIL stream_bcnt got %0d exp %0d", bcnt, bc0); end
    endtask

    task automatic test_stall();
        ent_t h, n;
        h = rnd_ent();
        n = rnd_ent();
        bus.out_ready = 1'b1;
        drive(1'b1, h);
        tick();
        bus.out_ready = 1'b1;
        stall = 1'b1;
        drive(1'b1, n);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0h exp 0", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0h exp 1", i, bus.out_valid); end
            checks++; if (bus.out_ctrl !== h.c) begin errors++; $display("FAIL stall_ctrl[%0d] got %0h exp %0h", i, bus.out_ctrl, h.c); end
            checks++; if (bus.out_data !== h.d) begin errors++; $display("FAIL stall_data[%0d] got %0h exp %0h", i, bus.out_data, h.d); end
        end
        stall = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL unstall_ready got %0h exp 1", bus.in_ready); end
        tick();
        drive(1'b0, n);
        checks++; if (bus.out_ctrl !== n.c) begin errors++; $display("FAIL unstall_ctrl got %0h exp %0h", bus.out_ctrl, n.c); end
        checks++; if (bus.out_data !== n.d) begin errors++; $display("FAIL unstall_data got %0h exp %0h", bus.out_data, n.d); end
    endtask

    task automatic test_flush();
        int bc_prev;
        bus.out_ready = 1'b1;
        drive(1'b1, rnd_ent());
        tick();
        bc_prev = m_cnt;
        flush = 1'b1;
        stall = 1'b1;
        drive(1'b1, rnd_ent());
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0h exp 0", bus.in_ready); end
        tick();
        flush = 1'b0;
        stall = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", bus.out_valid); end
        checks++; if (bus.out_ctrl !== '0) begin errors++; $display("FAIL flush_ctrl got %0h exp 0", bus.out_ctrl); end
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occ); end
        checks++; if (bcnt !== NW'(bc_prev + 1)) begin errors++; $display("FAIL flush_bcnt got %0d exp %0d", bcnt, bc_prev + 1); end
    endtask

    task automatic test_skid();
        ent_t e0, e1;
        e0 = rnd_ent();
        e1 = rnd_ent();
        bus.out_ready = 1'b0;
        drive(1'b1, e0);
        tick();
        drive(1'b1, e1);
`ifdef PIPE_SKID_EN
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready1 got %0h exp 1", bus.in_ready); end
        tick();
        drive(1'b1, rnd_ent());
        #1;
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL skid_occ2 got %0d exp 2", occ); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready got %0h exp 0", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (bus.out_ctrl !== e0.c) begin errors++; $display("FAIL skid_first got %0h exp %0h", bus.out_ctrl, e0.c); end
        tick();
        checks++; if (occ !== 2'd1) begin errors++; $display("FAIL skid_occ1 got %0d exp 1", occ); end
        checks++; if (bus.out_ctrl !== e1.c) begin errors++; $display("FAIL skid_second_c got %0h exp %0h", bus.out_ctrl, e1.c); end
        checks++; if (bus.out_data !== e1.d) begin errors++; $display("FAIL skid_second_d got %0h exp %0h", bus.out_data, e1.d); end
        tick();
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL skid_occ0 got %0d exp 0", occ); end
        checks++; if (bus.out_ctrl !== '0) begin errors++; $display("FAIL skid_empty_ctrl got %0h exp 0", bus.out_ctrl); end
`else
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL base_full_ready got %0h exp 0", bus.in_ready); end
        tick();
        checks++; if (occ !== 2'd1) begin errors++; $display("FAIL base_occ got %0d exp 1", occ); end
        checks++; if (bus.out_ctrl !== e0.c) begin errors++; $display("FAIL base_hold got %0h exp %0h", bus.out_ctrl, e0.c); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL base_drain got %0d exp 0", occ); end
`endif
    endtask

    task automatic test_random();
        logic [CW-1:0] ec;
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_ent());
            bus.out_ready = $urandom_range(0, 9) < 7;
            stall = $urandom_range(0, 9) == 0;
            flush = $urandom_range(0, 19) == 0;
            #1;
            ec = (mq.size() > 0) ? mq[0].c : '0;
            checks++; if (bus.in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready[%0d] got %0h exp %0h", i, bus.in_ready, exp_ready()); end
            checks++; if (bus.out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %0h exp %0h", i, bus.out_valid, mq.size() > 0); end
            checks++; if (bus.out_ctrl !== ec) begin errors++; $display("FAIL rnd_ctrl[%0d] got %0h exp %0h", i, bus.out_ctrl, ec); end
            if (mq.size() > 0) begin
                checks++; if (bus.out_data !== mq[0].d) begin errors++; $display("FAIL rnd_data[%0d] got %0h exp %0h", i, bus.out_data, mq[0].d); end
            end
            checks++; if (occ !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ[%0d] got %0d exp %0d", i, occ, mq.size()); end
            checks++; if (bcnt !== NW'(m_cnt)) begin errors++; $display("FAIL rnd_bcnt[%0d] got %0d exp %0d", i, bcnt, m_cnt); end
            tick();
        end
        stall = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_saturate();
        model_reset();
        #1;
        checks++; if (bcnt_s !== '0) begin errors++; $display("FAIL sat_rst got %0d exp 0", bcnt_s); end
        tick();
        resetn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) begin
                checks++; if (bcnt_s !== SW'(10)) begin errors++; $display("FAIL sat_mid got %0d exp 10", bcnt_s); end
            end
        end
        checks++; if (bcnt_s !== SW'(15)) begin errors++; $display("FAIL sat_end got %0d exp 15", bcnt_s); end
        checks++; if (bcnt !== NW'(m_cnt)) begin errors++; $display("FAIL sat_main got %0d exp %0d", bcnt, m_cnt); end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_ctrl     = '0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus_s.in_valid  = 1'b0;
        bus_s.in_ctrl   = '0;
        bus_s.in_data   = '0;
        bus_s.out_ready = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_skid();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
